// File: rtl/system_0_sysid_pkg.sv
// Shared types and constants for the system_0 sysid checker.
package system_0_sysid_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRdId = 2'd1,
        StRdTs = 2'd2,
        StDone = 2'd3
    } sysid_state_e;

    // Word offsets inside the sysid peripheral.
    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    // Values baked into the reference FPGA image.
    localparam logic [31:0] SYSID_DEFAULT_ID = 32'h0000_0000;
    localparam logic [31:0] SYSID_DEFAULT_TS = 32'h5FE3_EAFA;

    // Counter width able to hold 0..limit; a disabled (zero) limit still gets one bit.
    function automatic int unsigned wait_cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/system_0_wait_timer.sv
// Saturating wait-state counter. o_expired flags the enabled cycle that brings the
// count up to LIMIT, so a master can abort on that same edge. LIMIT=0 disables it.
module system_0_wait_timer
    import system_0_sysid_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned W       = wait_cnt_width(LIMIT);
    localparam bit          ENABLED = (LIMIT != 0);
    localparam logic [W-1:0] MAX    = W'(LIMIT);
    localparam logic [W-1:0] LAST   = W'((LIMIT == 0) ? 0 : LIMIT - 1);

    logic [W-1:0] r_count;

    // Count stall cycles, holding at LIMIT instead of wrapping.
    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = ENABLED && i_enable && (r_count == LAST);

endmodule

// File: rtl/system_0_sysid_checker.sv
// Avalon-MM master that reads sysid words 0 and 1, compares them with the expected
// build values and reports match / mismatch / timeout as registered status.
module system_0_sysid_checker
    import system_0_sysid_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = SYSID_DEFAULT_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = SYSID_DEFAULT_TS,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_start,
    output logic        o_avm_address,
    output logic        o_avm_read,
    input  logic        i_avm_waitrequest,
    input  logic [31:0] i_avm_readdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_id_ok,
    output logic        o_ts_ok,
    output logic        o_timeout,
    output logic [31:0] o_id_value,
    output logic [31:0] o_ts_value
);

    sysid_state_e r_state;
    logic         r_auto;
    logic         r_avm_read;
    logic         r_avm_address;
    logic         r_busy;
    logic         r_done;
    logic         r_id_ok;
    logic         r_ts_ok;
    logic         r_timeout;
    logic [31:0]  r_id_value;
    logic [31:0]  r_ts_value;

    logic w_in_read;
    logic w_tmr_clear;
    logic w_tmr_enable;
    logic w_tmr_expired;

    // The timer runs only while a read is stalled; it restarts whenever a read completes
    // or the FSM is outside the read states, so each read gets a fresh budget.
    assign w_in_read    = (r_state == StRdId) || (r_state == StRdTs);
    assign w_tmr_enable = w_in_read && i_avm_waitrequest;
    assign w_tmr_clear  = !w_in_read || !i_avm_waitrequest;

    system_0_wait_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_clear  (w_tmr_clear),
        .i_enable (w_tmr_enable),
        .o_expired(w_tmr_expired)
    );

    // Check sequencer: all bus strobes and status are registered on state transitions.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= StIdle;
            r_auto        <= AUTO_START;
            r_avm_read    <= 1'b0;
            r_avm_address <= SYSID_ADDR_ID;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout     <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start || r_auto) begin
                        r_auto        <= 1'b0;
                        r_state       <= StRdId;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= SYSID_ADDR_ID;
                        r_busy        <= 1'b1;
                    end
                end
                StRdId: begin
                    if (!i_avm_waitrequest) begin
                        r_id_value    <= i_avm_readdata;
                        r_id_ok       <= (i_avm_readdata == EXPECTED_ID);
                        r_avm_address <= SYSID_ADDR_TS;
                        r_state       <= StRdTs;
                    end else if (w_tmr_expired) begin
                        r_avm_read <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_state    <= StDone;
                    end
                end
                StRdTs: begin
                    if (!i_avm_waitrequest) begin
                        r_ts_value <= i_avm_readdata;
                        r_ts_ok    <= (i_avm_readdata == EXPECTED_TIMESTAMP);
                        r_avm_read <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= StDone;
                    end else if (w_tmr_expired) begin
                        r_avm_read <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_id_ok    <= 1'b0;
                        r_ts_ok    <= 1'b0;
                        r_state    <= StDone;
                    end
                end
                StDone: begin
                    if (i_start) begin
                        r_done        <= 1'b0;
                        r_id_ok       <= 1'b0;
                        r_ts_ok       <= 1'b0;
                        r_timeout     <= 1'b0;
                        r_avm_read    <= 1'b1;
                        r_avm_address <= SYSID_ADDR_ID;
                        r_busy        <= 1'b1;
                        r_state       <= StRdId;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_avm_read    = r_avm_read;
    assign o_avm_address = r_avm_address;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_id_ok       = r_id_ok;
    assign o_ts_ok       = r_ts_ok;
    assign o_timeout     = r_timeout;
    assign o_id_value    = r_id_value;
    assign o_ts_value    = r_ts_value;

endmodule

// File: doc/system_0_sysid_checker.md
# system_0_sysid_checker

Avalon-MM master that reads the system ID peripheral on the system_0 interconnect and verifies it against build-time expected values. It reads word 0 (ID) and word 1 (timestamp), latches both, and reports match, mismatch or timeout to the bring-up/status logic. It runs automatically after reset and can be re-run on demand, so host software and hardware can refuse to run against a mismatched FPGA image.

## Interface
- EXPECTED_ID, default 32'h0000_0000: required value at sysid word 0.
- EXPECTED_TIMESTAMP, default 32'd1608772346 (32'h5FE3_EAFA): required value at sysid word 1.
- TIMEOUT_CYCLES, default 255: maximum cycles a read may stall on waitrequest; 0 disables the timeout.
- AUTO_START, default 1: start a check on the first cycle after reset deasserts.

- clock, input, 1: single clock for all logic.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request a (re)check; sampled in IDLE and DONE only.
- avm_address, output, 1: word address; 0 is ID, 1 is timestamp.
- avm_read, output, 1: Avalon-MM read strobe.
- avm_waitrequest, input, 1: slave stall.
- avm_readdata, input, 32: read data, valid when avm_read=1 and avm_waitrequest=0.
- busy, output, 1: check in progress.
- done, output, 1: status outputs valid; a level held until the next start or reset.
- id_ok, output, 1: captured ID equals EXPECTED_ID.
- ts_ok, output, 1: captured timestamp equals EXPECTED_TIMESTAMP.
- timeout, output, 1: a read stalled for TIMEOUT_CYCLES cycles.
- id_value, output, 32: captured ID.
- ts_value, output, 32: captured timestamp.

## Operation
- The FSM has four states: IDLE, RD_ID, RD_TS and DONE. All outputs are registered.
- **Reset:** state goes to IDLE. avm_read, avm_address, busy, done, id_ok, ts_ok and timeout are 0. id_value and ts_value are 0.
- **IDLE → RD_ID:** taken on start=1, or on the first non-reset cycle when AUTO_START=1.
- **RD_ID:** avm_read=1, avm_address=0, busy=1.
  - On a cycle with avm_waitrequest=0: latch readdata into id_value, set id_ok = (readdata == EXPECTED_ID), go to RD_TS.
- **RD_TS:** avm_read=1, avm_address=1.
  - On completion: latch ts_value, set ts_ok, go to DONE.
- **DONE:** avm_read=0, busy=0, done=1.
  - start=1 clears done, id_ok, ts_ok and timeout, then enters RD_ID. id_value and ts_value are overwritten as the new reads complete.
- **Avalon rules:**
  - avm_address and avm_read are held stable while avm_waitrequest=1.
  - There is never more than one outstanding read, and no pipelining.
  - The slave may have zero wait states.
- **Timeout:**
  - A wait counter is cleared on entry to each read state and increments on each cycle with avm_waitrequest=1.
  - When the counter reaches TIMEOUT_CYCLES with avm_waitrequest still 1, avm_read drops, timeout=1, id_ok=ts_ok=0, and the FSM goes to DONE.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). The counter saturates and never wraps.
- start while busy is ignored and is not queued.
- Reset asserted mid-read: avm_read is 0 from the next edge and the in-flight read is abandoned.

## Timing
- Zero-wait-state slave, start sampled at edge N:
  - avm_read=1 and address=0 during cycle N→N+1.
  - Address=1 during N+1→N+2.
  - done=1 and flags valid from edge N+2.
  - Total latency is 2 cycles, plus any wait states.
- AUTO_START: the first read is issued on the cycle after the first non-reset edge.
- Each wait state adds one cycle per read.
- Timeout fires TIMEOUT_CYCLES cycles after the read is first asserted.
- done, id_ok, ts_ok, timeout, id_value and ts_value change only on state transitions.

## Structure
- Package system_0_sysid_pkg holds:
  - the state enum (IDLE, RD_ID, RD_TS, DONE);
  - the word offsets SYSID_ADDR_ID=0 and SYSID_ADDR_TS=1;
  - the default expected ID and timestamp constants.
- One sub-module, system_0_wait_timer: a parameterised saturating wait-state counter with clear, enable and expired outputs. It is reusable by other masters.

## Test plan
- **Auto-start against a zero-wait slave returning 0 / 1608772346:** done=1 two cycles after the start condition, id_ok=1, ts_ok=1, timeout=0, ts_value=32'h5FE3_EAFA.
- **Slave returns ID 32'h0000_0001:** done=1, id_ok=0, ts_ok=1, id_value=1.
- **Slave holds waitrequest=1 for 3 cycles per read:** completes at edge N+8, address and read stable throughout the stall, both flags=1.
- **waitrequest stuck high, TIMEOUT_CYCLES=4:** read drops after 4 stall cycles, done=1, timeout=1, id_ok=ts_ok=0. Then release waitrequest and pulse start: the check passes and timeout clears.
- **start pulsed in RD_TS:** ignored, exactly two reads issued. Reset asserted in RD_ID: next cycle avm_read=0 and all flags=0.
